sponge_stream_ctrl: RTL and testbench

- Generalised memory-to-hash-core streaming controller for the accelerator template.
- Reads a configurable number of 2×DATA_WIDTH lanes from two memory ports, starting at a programmable base address, and streams them into a sponge core (Keccak/SHAKE) over a valid/ready handshake with back-pressure.
- When the core finishes, squeezes a configurable number of output lanes and writes them to a separate base address, then reports done and status through accel_state/accel_error.

---
 rtl/sponge_stream_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sponge_stream_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sponge_stream_ctrl.sv
// Streams lanes from two memory ports into a sponge core, then writes the squeezed lanes back.
// Optional job cycle counter: define SPONGE_STREAM_PERF_CNT_EN.
package sponge_stream_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUNNING = 1'b1} acc_state_t;
  typedef enum logic {ER_OKAY = 1'b0, ER_INVALID_CFG = 1'b1} acc_error_t;
endpackage

module sponge_stream_ctrl
  import sponge_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LANES  = 21
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      done,
  output acc_state_t                accel_state,
  output acc_error_t                accel_error,
  input  logic [ADDR_WIDTH-1:0]     in_base,
  input  logic [ADDR_WIDTH-1:0]     out_base,
  input  logic [7:0]                in_lanes,
  input  logic [7:0]                out_lanes,
  output logic                      mem_en_a,
  output logic                      mem_en_b,
  output logic                      mem_we_a,
  output logic                      mem_we_b,
  output logic [ADDR_WIDTH-1:0]     mem_addr_a,
  output logic [ADDR_WIDTH-1:0]     mem_addr_b,
  output logic [DATA_WIDTH-1:0]     mem_wdata_a,
  output logic [DATA_WIDTH-1:0]     mem_wdata_b,
  output logic [DATA_WIDTH/8-1:0]   mem_be_a,
  output logic [DATA_WIDTH/8-1:0]   mem_be_b,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_a,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_b,
  output logic                      core_start,
  output logic [2*DATA_WIDTH-1:0]   core_din,
  output logic                      core_din_valid,
  output logic                      core_last,
  input  logic                      core_din_ready,
  input  logic                      core_ready,
  input  logic [2*DATA_WIDTH-1:0]   core_dout,
  input  logic                      core_dout_valid,
  output logic                      core_dout_ready,
  output logic [31:0]               cycle_cnt
);
  localparam int LW = 2 * DATA_WIDTH;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_FEED, S_WAIT, S_WRITE} fsm_t;

  fsm_t                  r_st;
  logic [ADDR_WIDTH-1:0] r_in_base, r_out_base;
  logic [7:0]            r_in_lanes, r_out_lanes, r_issued, r_popped, r_written;
  logic                  r_inflight;
  logic [LW-1:0]         r_fifo [2];
  logic                  r_wptr, r_rptr;
  logic [1:0]            r_count;
  logic                  r_done, r_core_start;
  acc_state_t            r_acc_state;
  acc_error_t            r_acc_error;

  logic                  w_cfg_bad, w_pop, w_issue, w_wr_hs;
  logic [1:0]            w_occ;
  logic [ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;

  assign w_cfg_bad = (in_lanes == 8'd0) || (out_lanes == 8'd0) ||
                     (in_lanes > 8'(MAX_LANES)) || (out_lanes > 8'(MAX_LANES));

  assign core_din_valid = (r_count != 2'd0);
  assign core_din       = core_din_valid ? r_fifo[r_rptr] : '0;
  assign core_last      = core_din_valid && (r_popped == r_in_lanes - 8'd1);
  assign w_pop          = core_din_valid && core_din_ready;

  // Occupancy the FIFO will hold after this cycle, counting the read already in flight
  assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = (r_st == S_FEED) && (w_occ <= 2'd1) && (r_issued < r_in_lanes);

  assign core_dout_ready = (r_st == S_WRITE) && (r_written < r_out_lanes);
  assign w_wr_hs         = core_dout_ready && core_dout_valid;

  assign w_rd_addr = r_in_base  + ADDR_WIDTH'({r_issued, 1'b0});
  assign w_wr_addr = r_out_base + ADDR_WIDTH'({r_written, 1'b0});

  assign mem_en_a    = w_issue || w_wr_hs;
  assign mem_en_b    = w_issue || w_wr_hs;
  assign mem_we_a    = w_wr_hs;
  assign mem_we_b    = w_wr_hs;
  assign mem_addr_a  = w_wr_hs ? w_wr_addr : (w_issue ? w_rd_addr : '0);
  assign mem_addr_b  = w_wr_hs ? w_wr_addr + ADDR_WIDTH'(1) :
                       (w_issue ? w_rd_addr + ADDR_WIDTH'(1) : '0);
  assign mem_wdata_a = w_wr_hs ? core_dout[DATA_WIDTH-1:0] : '0;
  assign mem_wdata_b = w_wr_hs ? core_dout[LW-1:DATA_WIDTH] : '0;
  assign mem_be_a    = {BW{w_wr_hs}};
  assign mem_be_b    = {BW{w_wr_hs}};

  assign done        = r_done;
  assign core_start  = r_core_start;
  assign accel_state = r_acc_state;
  assign accel_error = r_acc_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st         <= S_IDLE;
      r_in_base    <= '0;
      r_out_base   <= '0;
      r_in_lanes   <= '0;
      r_out_lanes  <= '0;
      r_issued     <= '0;
      r_popped     <= '0;
      r_written    <= '0;
      r_inflight   <= 1'b0;
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= '0;
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
      r_acc_state  <= ST_IDLE;
      r_acc_error  <= ER_OKAY;
    end else begin
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
      r_inflight   <= w_issue;
      r_count      <= w_occ;
      if (w_issue) r_issued <= r_issued + 8'd1;
      if (r_inflight) begin
        r_fifo[r_wptr] <= {mem_rdata_b, mem_rdata_a};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr   <= ~r_rptr;
        r_popped <= r_popped + 8'd1;
      end
      if (w_wr_hs) r_written <= r_written + 8'd1;
      case (r_st)
        S_IDLE: if (start) begin
          r_in_base   <= in_base;
          r_out_base  <= out_base;
          r_in_lanes  <= in_lanes;
          r_out_lanes <= out_lanes;
          r_issued    <= '0;
          r_popped    <= '0;
          r_written   <= '0;
          if (w_cfg_bad) begin
            r_st        <= S_ERR;
            r_done      <= 1'b1;
            r_acc_error <= ER_INVALID_CFG;
          end else begin
            r_st         <= S_FEED;
            r_core_start <= 1'b1;
            r_acc_error  <= ER_OKAY;
            r_acc_state  <= ST_RUNNING;
          end
        end
        S_ERR:  r_st <= S_IDLE;
        S_FEED: if (w_pop && core_last) r_st <= S_WAIT;
        S_WAIT: if (core_ready) r_st <= S_WRITE;
        S_WRITE: if (w_wr_hs && (r_written == r_out_lanes - 8'd1)) begin
          r_st        <= S_IDLE;
          r_done      <= 1'b1;
          r_acc_state <= ST_IDLE;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

`ifdef SPONGE_STREAM_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cycle_cnt <= '0;
    else if ((r_st == S_IDLE) && start)
      r_cycle_cnt <= '0;
    else if (((r_st == S_FEED) || (r_st == S_WAIT) || (r_st == S_WRITE)) && (r_cycle_cnt != '1))
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end
  assign cycle_cnt = r_cycle_cnt;
`else
  assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_sponge_stream_ctrl.sv
// Scoreboard bench for sponge_stream_ctrl: random jobs against a queue-based reference of reads, lanes and writes.
module tb_sponge_stream_ctrl;
  import sponge_stream_pkg::*;
  localparam int AW = 32, DW = 32, MAXL = 21;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic done, mem_en_a, mem_en_b, mem_we_a, mem_we_b, core_start, core_din_valid, core_last;
  logic core_din_ready, core_ready, core_dout_valid, core_dout_ready;
  acc_state_t accel_state;
  acc_error_t accel_error;
  logic [AW-1:0] in_base, out_base, mem_addr_a, mem_addr_b;
  logic [7:0] in_lanes, out_lanes;
  logic [DW-1:0] mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic [DW/8-1:0] mem_be_a, mem_be_b;
  logic [2*DW-1:0] core_din, core_dout;
  logic [31:0] cycle_cnt;

  sponge_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LANES(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .accel_state(accel_state),
    .accel_error(accel_error), .in_base(in_base), .out_base(out_base), .in_lanes(in_lanes),
    .out_lanes(out_lanes), .mem_en_a(mem_en_a), .mem_en_b(mem_en_b), .mem_we_a(mem_we_a),
    .mem_we_b(mem_we_b), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_wdata_a(mem_wdata_a), .mem_wdata_b(mem_wdata_b), .mem_be_a(mem_be_a), .mem_be_b(mem_be_b),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b), .core_start(core_start),
    .core_din(core_din), .core_din_valid(core_din_valid), .core_last(core_last),
    .core_din_ready(core_din_ready), .core_ready(core_ready), .core_dout(core_dout),
    .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready), .cycle_cnt(cycle_cnt));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic all_outs_or;
  assign all_outs_or = |{done, accel_state, accel_error, mem_en_a, mem_en_b, mem_we_a, mem_we_b,
                         mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b, mem_be_a, mem_be_b,
                         core_start, core_din, core_din_valid, core_last, core_dout_ready, cycle_cnt};

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  // Reference expectations
  logic [AW-1:0] exp_rd_a[$], exp_rd_b[$];
  logic [2*DW:0] exp_din[$];
  logic [AW+DW-1:0] exp_wa[$], exp_wb[$];
  logic exp_done[$];
  logic [2*DW-1:0] dout_vals[$];

  // Observations shared with the stimulus
  int n_rd, n_pop, done_cnt = 0, done_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  int core_start_cnt, core_start_cyc, last_rd_cyc;
  bit first_valid_seen;
  int ready_mode = 0, cfg_dly = 0;

  // Memory: read data valid the cycle after an enable without write
  initial begin : memory
    logic rda, rdb;
    logic [AW-1:0] aa, ab;
    mem_rdata_a = '0; mem_rdata_b = '0;
    forever begin
      @(negedge clk);
      rda = mem_en_a && !mem_we_a; rdb = mem_en_b && !mem_we_b;
      aa = mem_addr_a; ab = mem_addr_b;
      @(posedge clk); #1;
      mem_rdata_a = rda ? mem_f(aa) : $urandom();
      mem_rdata_b = rdb ? mem_f(ab) : $urandom();
    end
  end

  // Sponge core model: absorb with ready pattern, delay, then squeeze dout_vals
  initial begin : core_model
    int ph, dly, oi;
    logic dlast, ohs, s_start, s_done, rs, tog;
    ph = 0; dly = 0; oi = 0; tog = 1'b0;
    core_din_ready = 1'b0; core_ready = 1'b0; core_dout = '0; core_dout_valid = 1'b0;
    forever begin
      @(negedge clk);
      dlast = core_din_valid && core_din_ready && core_last;
      ohs = core_dout_valid && core_dout_ready;
      s_start = core_start; s_done = done; rs = rst_n;
      @(posedge clk); #1;
      if (!rs) ph = 0;
      else begin
        if (s_start) begin ph = 1; oi = 0; end
        if (dlast) begin ph = 2; dly = cfg_dly; end
        if (ph == 2) begin if (dly == 0) ph = 3; else dly--; end
        if (ohs) oi++;
        if (s_done) ph = 0;
      end
      tog = ~tog;
      core_din_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? tog : 1'($urandom_range(0, 1));
      core_ready = (ph == 3);
      core_dout_valid = (ph == 3) && ($urandom_range(0, 3) != 0);
      core_dout = (oi < dout_vals.size()) ? dout_vals[oi] : 64'hDEADBEEF0BADF00D;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction
  initial begin : monitor
    logic [AW-1:0] ea, eb;
    logic [2*DW:0] ed;
    logic [AW+DW-1:0] wa, wb;
    logic ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_start) begin core_start_cnt++; core_start_cyc = cyc; end
        if (core_din_valid && !first_valid_seen) begin
          first_valid_seen = 1; first_valid_cyc = cyc;
          chk("state_running", accel_state, ST_RUNNING);
        end
        if (mem_en_b) chk("en_pair", mem_en_a, 1);
        if (mem_en_a && !mem_we_a) begin
          chk("rd_expected", exp_rd_a.size() != 0, 1);
          if (exp_rd_a.size() != 0) begin
            ea = exp_rd_a.pop_front(); eb = exp_rd_b.pop_front();
            chk("rd_addr_a", mem_addr_a, ea);
            chk("rd_addr_b", {mem_en_b, mem_we_b, mem_addr_b}, {2'b10, eb});
          end
          n_rd++; last_rd_cyc = cyc;
        end
        if (core_din_valid && core_din_ready) begin
          chk("din_expected", exp_din.size() != 0, 1);
          if (exp_din.size() != 0) begin
            ed = exp_din.pop_front();
            chk("din_lane", {core_last, core_din}, ed);
          end
          if (n_pop == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc; n_pop++;
        end
        if (mem_en_a && !mem_we_a) chk("fifo_bound", (n_rd - n_pop) <= 2, 1);
        if (mem_en_a && mem_we_a) begin
          chk("wr_expected", exp_wa.size() != 0, 1);
          if (exp_wa.size() != 0) begin
            wa = exp_wa.pop_front(); wb = exp_wb.pop_front();
            chk("wr_a", {mem_addr_a, mem_wdata_a}, wa);
            chk("wr_b", {mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b}, {2'b11, wb});
            chk("wr_be", {mem_be_a, mem_be_b}, 8'hFF);
          end
        end
        if (done) begin
          chk("done_expected", exp_done.size() != 0, 1);
          if (exp_done.size() != 0) begin
            ee = exp_done.pop_front();
            chk("done_err", accel_error, ee);
          end
          chk("state_idle_at_done", accel_state, ST_IDLE);
          done_cnt++; done_cyc = cyc;
        end
      end
    end
  end

  task automatic run_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                         input int il, input int ol, input int md, input int dl);
    bit bad;
    int t0, n, dc0;
    logic [2*DW-1:0] v, ln;
    bad = (il == 0) || (ol == 0) || (il > MAXL) || (ol > MAXL);
    dout_vals.delete();
    if (!bad) begin
      for (int i = 0; i < il; i++) begin
        exp_rd_a.push_back(ib + AW'(2 * i));
        exp_rd_b.push_back(ib + AW'(2 * i + 1));
        ln = {mem_f(ib + AW'(2 * i + 1)), mem_f(ib + AW'(2 * i))};
        exp_din.push_back({(i == il - 1), ln});
      end
      for (int j = 0; j < ol; j++) begin
        v = {$urandom(), $urandom()};
        dout_vals.push_back(v);
        exp_wa.push_back({ob + AW'(2 * j), v[DW-1:0]});
        exp_wb.push_back({ob + AW'(2 * j + 1), v[2*DW-1:DW]});
      end
    end
    exp_done.push_back(bad ? ER_INVALID_CFG : ER_OKAY);
    ready_mode = md; cfg_dly = dl;
    n_rd = 0; n_pop = 0; first_valid_seen = 0; core_start_cnt = 0; dc0 = done_cnt;
    in_base = ib; out_base = ob; in_lanes = 8'(il); out_lanes = 8'(ol);
    start = 1'b1; t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    in_base = $urandom(); out_base = $urandom(); in_lanes = 8'($urandom()); out_lanes = 8'($urandom());
    @(posedge clk); #1;
    if (!bad) start = 1'b1;   // arrives mid-job, must be ignored
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done_cnt == dc0 && n < 3000) begin @(negedge clk); #1; n++; end
    chk("done_seen", done_cnt != dc0, 1);
    if (bad) begin
      chk("err_done_lat", done_cyc - t0, 1);
      chk("err_no_rd", n_rd, 0);
    end else begin
      chk("first_valid_lat", first_valid_cyc - t0, 3);
      chk("core_start_cyc", core_start_cyc - t0, 1);
      chk("core_start_cnt", core_start_cnt, 1);
      chk("lanes_popped", n_pop, il);
      if (md == 0) chk("throughput", last_pop_cyc - first_pop_cyc, il - 1);
    end
`ifdef SPONGE_STREAM_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, bad ? 0 : done_cyc - t0 - 1);
`else
    chk("cycle_cnt_zero", cycle_cnt, 0);
`endif
    repeat (3) begin @(negedge clk); #1; end
`ifdef SPONGE_STREAM_PERF_CNT_EN
    chk("cycle_cnt_hold", cycle_cnt, bad ? 0 : done_cyc - t0 - 1);
`endif
    chk("done_once", done_cnt - dc0, 1);
    chk("err_hold", accel_error, bad ? ER_INVALID_CFG : ER_OKAY);
    chk("q_rd_empty", exp_rd_a.size(), 0);
    chk("q_din_empty", exp_din.size(), 0);
    chk("q_wr_empty", exp_wa.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    int n, il, ol;
    in_base = '0; out_base = '0; in_lanes = '0; out_lanes = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_outs", all_outs_or, 0);
    chk("rst_state", accel_state, ST_IDLE);
    chk("rst_err", accel_error, ER_OKAY);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run_job($urandom(), $urandom(), 21, 2, 0, 3);
    run_job($urandom(), $urandom(), 5, 3, 1, 2);
    run_job($urandom(), $urandom(), 0, 2, 0, 1);
    run_job($urandom(), $urandom(), 3, 22, 0, 1);
    run_job($urandom(), $urandom(), 2, 2, 2, 1);
    run_job(32'hFFFFFFFE, 32'hFFFFFFFF, 2, 1, 0, 2);

    // Reset while a read is in flight, then a fresh job must start at lane 0
    ready_mode = 2; cfg_dly = 2; n_rd = 0; n_pop = 0;
    in_base = $urandom(); out_base = $urandom(); in_lanes = 8'd21; out_lanes = 8'd4;
    for (int i = 0; i < 21; i++) begin
      exp_rd_a.push_back(in_base + AW'(2 * i));
      exp_rd_b.push_back(in_base + AW'(2 * i + 1));
      exp_din.push_back({(i == 20), mem_f(in_base + AW'(2 * i + 1)), mem_f(in_base + AW'(2 * i))});
    end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!(n_rd >= 3 && last_rd_cyc == cyc) && n < 200) begin @(negedge clk); #1; n++; end
    chk("midrst_rd_seen", n_rd >= 3, 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_outs", all_outs_or, 0);
    chk("midrst_state", accel_state, ST_IDLE);
    exp_rd_a.delete(); exp_rd_b.delete(); exp_din.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_job($urandom(), $urandom(), 21, 2, 0, 0);

    run_job($urandom(), $urandom(), 1, 1, 0, 4);

    for (int k = 0; k < 12; k++) begin
      il = ($urandom_range(0, 7) == 0) ? int'($urandom_range(22, 255)) : int'($urandom_range(1, 21));
      ol = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 21));
      run_job($urandom(), $urandom(), il, ol, int'($urandom_range(0, 2)), int'($urandom_range(0, 6)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
